// File: rtl/jimmy_pkg.sv
// jimmy boot controller shared types and constants.
// Imported by the instruction RAM and the boot FSM.
package jimmy_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] NOP_BYTE = 8'h70;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LEN,
        DATA,
        CSUM,
        RUN,
        ERROR
    } boot_state_t;

endpackage

// File: rtl/jimmy_inst_ram.sv
// 256x8 instruction memory: synchronous write, asynchronous read.
// Contents survive reset; only explicit writes change them.
module jimmy_inst_ram
    import jimmy_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/jimmy_boot_ctrl.sv
// Boot/program-load controller: clears and loads instruction memory,
// verifies the checksum and releases the CPU from reset on success.
module jimmy_boot_ctrl
    import jimmy_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              cpu_reset,
    input  logic [ADDR_W-1:0] inst_address_bus,
    output logic [DATA_W-1:0] inst_data_bus,
    output logic              busy,
    output logic              done,
    output logic              err
);

    boot_state_t       state, state_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic [ADDR_W:0]   len, len_n;
    logic [DATA_W-1:0] sum, sum_n;
    logic              accept;
    logic              last_data;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;

    assign in_ready = (state == LEN || state == DATA || state == CSUM)
                      && !load_start;
    assign accept    = in_valid & in_ready;
    assign last_data = ({1'b0, cnt} == (len - 9'd1));

    assign mem_we    = (state == CLEAR && !load_start)
                     || (state == DATA && accept);
    assign mem_wdata = (state == CLEAR) ? NOP_BYTE : in_data;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        len_n   = len;
        sum_n   = sum;
        if (load_start) begin
            state_n = CLEAR;
            cnt_n   = '0;
        end else begin
            unique case (state)
                CLEAR: begin
                    cnt_n = cnt + 8'd1;
                    if (cnt == 8'hFF) begin
                        state_n = LEN;
                    end
                end
                LEN: begin
                    if (accept) begin
                        // a zero length byte encodes a full 256-byte image
                        len_n   = (in_data == 8'd0) ? 9'd256
                                                    : {1'b0, in_data};
                        cnt_n   = '0;
                        sum_n   = '0;
                        state_n = DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        sum_n = sum + in_data;
                        cnt_n = cnt + 8'd1;
                        if (last_data) begin
                            state_n = CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (accept) begin
                        state_n = (8'(sum + in_data) == 8'd0) ? RUN : ERROR;
                    end
                end
                default: begin
                    state_n = state;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            len       <= '0;
            sum       <= '0;
            cpu_reset <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            len       <= len_n;
            sum       <= sum_n;
            cpu_reset <= (state_n == RUN);
            done      <= (state_n == RUN);
            err       <= (state_n == ERROR);
            busy      <= state_n inside {CLEAR, LEN, DATA, CSUM};
        end
    end

    jimmy_inst_ram u_ram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (cnt),
        .wdata (mem_wdata),
        .raddr (inst_address_bus),
        .rdata (inst_data_bus)
    );

endmodule

// File: tb/tb_jimmy_boot_ctrl.sv
// Self-checking bench for jimmy_boot_ctrl: reference memory model,
// readback scoreboard and a small table of directed readback vectors.
module tb_jimmy_boot_ctrl;
    import jimmy_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_start = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       cpu_reset;
    logic [7:0] inst_address_bus = 8'h00;
    logic [7:0] inst_data_bus;
    logic       busy;
    logic       done;
    logic       err;

    jimmy_boot_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .load_start       (load_start),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .cpu_reset        (cpu_reset),
        .inst_address_bus (inst_address_bus),
        .inst_data_bus    (inst_data_bus),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } rd_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] ref_mem [256];
    rd_t        sb [$];
    rd_t        vec [5];

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        rd_t r;
        while (sb.size() > 0) begin
            r = sb.pop_front();
            inst_address_bus = r.addr;
            #1;
            chk($sformatf("mem[%02h]", r.addr), inst_data_bus, r.data);
        end
    endtask

    task automatic push_all();
        for (int a = 0; a < 256; a++) begin
            sb.push_back('{addr: 8'(a), data: ref_mem[a]});
        end
    endtask

    task automatic wait_clear();
        int k = 0;
        load_start = 1'b0;
        #1;
        while (!in_ready && k < 600) begin
            step();
            k++;
        end
        chk("clear_cycles", k, 256);
        chk("busy_in_len", busy, 1'b1);
        for (int a = 0; a < 256; a++) ref_mem[a] = NOP_BYTE;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'h5A;
        #1;
        chk("ready_on_start", in_ready, 1'b0);
        step();
        wait_clear();
    endtask

    task automatic send_byte(logic [7:0] b, bit bp);
        int  w   = 0;
        bit  got = 0;
        in_data = b;
        while (!got && w < 500) begin
            in_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (in_valid && in_ready) got = 1;
            step();
            w++;
        end
        if (!got) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic load_body(logic [7:0] n, logic [7:0] d [$],
                             logic [7:0] k, bit bp);
        logic [7:0] s = 8'h00;
        bit         ok;
        send_byte(n, bp);
        for (int i = 0; i < d.size(); i++) begin
            send_byte(d[i], bp);
            ref_mem[i] = d[i];
            s = s + d[i];
        end
        send_byte(k, bp);
        ok = (8'(s + k) == 8'h00);
        #1;
        chk("done", done, ok);
        chk("err", err, !ok);
        chk("cpu_reset", cpu_reset, ok);
        chk("busy_end", busy, 1'b0);
        chk("ready_end", in_ready, 1'b0);
    endtask

    logic [7:0] d [$];
    logic [7:0] ksum;

    initial begin
        reset = 1'b0;
        #1;
        chk("rst_cpu_reset", cpu_reset, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_ready", in_ready, 1'b0);
        step();
        reset = 1'b1;
        step();
        chk("idle_after_rst", 32'(dut.state), 32'(IDLE));

        // good load
        start_load();
        d = '{8'h80, 8'h05, 8'h70};
        load_body(8'd3, d, 8'h0B, 0);
        vec[0] = '{8'h00, 8'h80};
        vec[1] = '{8'h01, 8'h05};
        vec[2] = '{8'h02, 8'h70};
        vec[3] = '{8'h03, 8'h70};
        vec[4] = '{8'hFF, 8'h70};
        for (int i = 0; i < 5; i++) sb.push_back(vec[i]);
        drain();

        // async reset mid-RUN
        #2;
        reset = 1'b0;
        #1;
        chk("arst_cpu_reset", cpu_reset, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_err", err, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_ready", in_ready, 1'b0);
        reset = 1'b1;
        in_valid = 1'b1;
        step();
        chk("arst_idle", 32'(dut.state), 32'(IDLE));
        chk("idle_no_ready", in_ready, 1'b0);
        in_valid = 1'b0;
        sb.push_back('{8'h00, 8'h80});
        drain();

        // bad checksum
        start_load();
        d = '{8'h80, 8'h05, 8'h70};
        load_body(8'd3, d, 8'h0C, 0);
        push_all();
        drain();

        // N = 0 (256 bytes)
        start_load();
        d.delete();
        for (int i = 0; i < 256; i++) d.push_back(8'(i));
        load_body(8'd0, d, 8'h80, 0);
        sb.push_back('{8'hFF, 8'hFF});
        sb.push_back('{8'h00, 8'h00});
        push_all();
        drain();

        // restart mid-DATA
        start_load();
        send_byte(8'd5, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        load_start = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'hAA;
        #1;
        chk("restart_no_ready", in_ready, 1'b0);
        step();
        in_valid = 1'b0;
        chk("restart_busy", busy, 1'b1);
        chk("restart_clear", 32'(dut.state), 32'(CLEAR));
        wait_clear();
        sb.push_back('{8'h00, 8'h70});
        sb.push_back('{8'h01, 8'h70});
        sb.push_back('{8'h02, 8'h70});
        drain();
        d = '{8'h10};
        load_body(8'd1, d, 8'hF0, 0);

        // backpressure with random data
        start_load();
        d.delete();
        ksum = 8'h00;
        for (int i = 0; i < 20; i++) begin
            d.push_back(8'($urandom_range(0, 255)));
            ksum = ksum - d[i];
        end
        load_body(8'd20, d, ksum, 1);
        push_all();
        drain();

        start_load();
        d.delete();
        for (int i = 0; i < 7; i++) d.push_back(8'($urandom_range(0, 255)));
        load_body(8'd7, d, 8'($urandom_range(0, 255)), 1);
        push_all();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
